// File: rtl/demux_router_if.sv
// demux_router_if: valid/ready bus between one producer and the N consumers of demux_router.
// When DEMUX_ROUTER_BCAST_EN is defined, the in_bcast signal is added.
interface demux_router_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 8,
    parameter int unsigned SEL_W = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [SEL_W-1:0]     in_sel;
`ifdef DEMUX_ROUTER_BCAST_EN
    logic                 in_bcast;
`endif
    logic [N-1:0]         out_valid;
    logic [N-1:0]         out_ready;
    logic [N*WIDTH-1:0]   out_data;

    // Producer/consumer side (drives words in, takes words out)
    modport master (
`ifdef DEMUX_ROUTER_BCAST_EN
        output in_bcast,
`endif
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Router side
    modport slave (
`ifdef DEMUX_ROUTER_BCAST_EN
        input  in_bcast,
`endif
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_router.sv
// demux_router: registered 1-to-N demultiplexer, one holding register per output channel.
// Words addressed to a channel index >= N are consumed, dropped and counted.
// Optional feature macro: DEMUX_ROUTER_BCAST_EN (adds in_bcast, load all channels at once).
module demux_router #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 8,
    parameter int unsigned SEL_W = 3
) (
    input  logic                clk,
    input  logic                resetn,
    demux_router_if.slave       bus,
    output logic [7:0]          drop_cnt,
    output logic                sel_err
);
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]       valid_q;
    logic [N*WIDTH-1:0] data_q;
    logic [CNT_W-1:0]   drop_q;
    logic               err_q;

    logic [N-1:0]       free_c;
    logic [N-1:0]       hit_c;
    logic [N-1:0]       load_c;
    logic               legal_c;
    logic               bcast_c;
    logic               ready_c;
    logic               accept_c;
    logic               drop_c;

    // Decode destination, compute readiness and per-channel load strobes
    always_comb begin
        free_c  = ~valid_q | bus.out_ready;
        legal_c = (32'(bus.in_sel) < N);
        hit_c   = '0;
        for (int i = 0; i < int'(N); i++) begin
            hit_c[i] = legal_c && (bus.in_sel == SEL_W'(i));
        end
`ifdef DEMUX_ROUTER_BCAST_EN
        bcast_c = bus.in_bcast;
`else
        bcast_c = 1'b0;
`endif
        if (bcast_c) begin
            ready_c = &free_c;
        end else if (legal_c) begin
            ready_c = |(hit_c & free_c);
        end else begin
            ready_c = 1'b1;
        end
        accept_c = bus.in_valid & ready_c;
        load_c   = bcast_c ? {N{accept_c}} : (hit_c & {N{accept_c}});
        drop_c   = accept_c & ~legal_c & ~bcast_c;
    end

    // Channel holding registers: load wins over drain on the same edge
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (load_c[i]) begin
                    valid_q[i]                <= 1'b1;
                    data_q[i*WIDTH +: WIDTH]  <= bus.in_data;
                end else if (bus.out_ready[i]) begin
                    valid_q[i]                <= 1'b0;
                end
            end
        end
    end

    // Saturating drop counter and sticky illegal-select flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            drop_q <= '0;
            err_q  <= 1'b0;
        end else if (drop_c) begin
            err_q <= 1'b1;
            if (drop_q != CNT_MAX) begin
                drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign drop_cnt      = drop_q;
    assign sel_err       = err_q;
endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: two routers (N=8 and N=6) driven in lockstep and checked against
// an array-based reference model of the channel registers and drop bookkeeping.
module tb_demux_router;
    logic clk = 1'b0;
    logic resetn;
    logic       tv;
    logic [7:0] td;
    logic [2:0] ts;
    logic [7:0] tr;
`ifdef DEMUX_ROUTER_BCAST_EN
    logic       tbc;
`endif

    always #5 clk = ~clk;

    demux_router_if #(.WIDTH(8), .N(8), .SEL_W(3)) b8();
    demux_router_if #(.WIDTH(8), .N(6), .SEL_W(3)) b6();

    assign b8.in_valid  = tv;
    assign b8.in_data   = td;
    assign b8.in_sel    = ts;
    assign b8.out_ready = tr;
    assign b6.in_valid  = tv;
    assign b6.in_data   = td;
    assign b6.in_sel    = ts;
    assign b6.out_ready = tr[5:0];
`ifdef DEMUX_ROUTER_BCAST_EN
    assign b8.in_bcast  = tbc;
    assign b6.in_bcast  = tbc;
`endif

    logic [7:0]  dc [2];
    logic        se [2];
    logic        ir [2];
    logic [7:0]  ov [2];
    logic [63:0] od [2];

    demux_router #(.WIDTH(8), .N(8), .SEL_W(3)) u8 (
        .clk(clk), .resetn(resetn), .bus(b8.slave), .drop_cnt(dc[0]), .sel_err(se[0])
    );
    demux_router #(.WIDTH(8), .N(6), .SEL_W(3)) u6 (
        .clk(clk), .resetn(resetn), .bus(b6.slave), .drop_cnt(dc[1]), .sel_err(se[1])
    );

    assign ir[0] = b8.in_ready;
    assign ir[1] = b6.in_ready;
    assign ov[0] = b8.out_valid;
    assign ov[1] = {2'b00, b6.out_valid};
    assign od[0] = b8.out_data;
    assign od[1] = {16'h0000, b6.out_data};

    // Reference model
    int         nch [2] = '{8, 6};
    bit         mv [2][8];
    logic [7:0] md [2][8];
    int         mdrop [2];
    bit         merr [2];
    bit         last_stall;

    int passes = 0;
    int total  = 0;

    function automatic bit is_bcast();
`ifdef DEMUX_ROUTER_BCAST_EN
        return tbc;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_ready(int k);
        bit r;
        if (is_bcast()) begin
            r = 1'b1;
            for (int c = 0; c < nch[k]; c++) r = r && (!mv[k][c] || tr[c]);
            return r;
        end
        if (int'(ts) >= nch[k]) return 1'b1;
        return !mv[k][ts] || tr[ts];
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    // One clock: check readiness before the edge, advance the model, check registers after
    task automatic cycle();
        bit         acc [2];
        logic [7:0]  ev;
        logic [63:0] ed;
        #1;
        for (int k = 0; k < 2; k++) begin
            acc[k] = resetn && tv && exp_ready(k);
            if (resetn) chk($sformatf("ready_n%0d", nch[k]), 64'(ir[k]), 64'(exp_ready(k)));
        end
        last_stall = resetn && tv && !(exp_ready(0) && exp_ready(1));
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                for (int c = 0; c < 8; c++) begin
                    mv[k][c] = 1'b0;
                    md[k][c] = 8'h00;
                end
                mdrop[k] = 0;
                merr[k]  = 1'b0;
            end else begin
                for (int c = 0; c < nch[k]; c++) begin
                    if (acc[k] && (is_bcast() || int'(ts) == c)) begin
                        mv[k][c] = 1'b1;
                        md[k][c] = td;
                    end else if (tr[c]) begin
                        mv[k][c] = 1'b0;
                    end
                end
                if (acc[k] && !is_bcast() && int'(ts) >= nch[k]) begin
                    merr[k] = 1'b1;
                    if (mdrop[k] < 255) mdrop[k]++;
                end
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            ev = '0;
            ed = '0;
            for (int c = 0; c < nch[k]; c++) begin
                ev[c]        = mv[k][c];
                ed[c*8 +: 8] = md[k][c];
            end
            chk($sformatf("valid_n%0d", nch[k]), 64'(ov[k]), 64'(ev));
            chk($sformatf("data_n%0d", nch[k]), od[k], ed);
            chk($sformatf("drop_n%0d", nch[k]), 64'(dc[k]), 64'(mdrop[k]));
            chk($sformatf("err_n%0d", nch[k]), 64'(se[k]), 64'(merr[k]));
        end
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        tv = 1'b1; td = 8'h5A; ts = 3'd0; tr = 8'h00;
        last_stall = 1'b0;
`ifdef DEMUX_ROUTER_BCAST_EN
        tbc = 1'b0;
`endif
        @(negedge clk);

        // Reset held two cycles with a word offered
        cycle();
        cycle();
        chk("rst_valid", 64'(ov[0]), 64'h0);
        chk("rst_drop", 64'(dc[0]), 64'h0);
        chk("rst_err", 64'(se[0]), 64'h0);

        // First edge after release accepts sel=0
        resetn = 1'b1; tr = 8'hFF; td = 8'h11; ts = 3'd0;
        #1 chk("post_rst_ready", 64'(ir[0]), 64'h1);
        cycle();
        chk("post_rst_load", 64'(ov[0]), 64'h01);

        // Unicast to channel 3, then drain
        td = 8'hA5; ts = 3'd3;
        cycle();
        chk("uni_valid", 64'(ov[0]), 64'h08);
        chk("uni_data", 64'(od[0][31:24]), 64'hA5);
        tv = 1'b0;
        cycle();
        chk("uni_drain", 64'(ov[0]), 64'h00);
        chk("uni_hold", 64'(od[0][31:24]), 64'hA5);

        // Back-pressure on channel 5
        tr = 8'hDF; tv = 1'b1; ts = 3'd5; td = 8'h11;
        cycle();
        chk("bp_first_valid", 64'(ov[0][5]), 64'h1);
        chk("bp_first_data", 64'(od[0][47:40]), 64'h11);
        td = 8'h22;
        #1 chk("bp_stall_ready", 64'(ir[0]), 64'h0);
        cycle();
        chk("bp_still_11", 64'(od[0][47:40]), 64'h11);
        tr = 8'hFF;
        #1 chk("bp_release_ready", 64'(ir[0]), 64'h1);
        cycle();
        chk("bp_load_22", 64'(od[0][47:40]), 64'h22);
        chk("bp_valid_kept", 64'(ov[0][5]), 64'h1);

        // Channel independence: channel 2 stalled full, traffic to 6 flows
        tr = 8'hFB; ts = 3'd2; td = 8'h77;
        cycle();
        ts = 3'd6; td = 8'h66;
        #1 chk("indep_ready", 64'(ir[0]), 64'h1);
        cycle();
        chk("indep_ch6", 64'(ov[0][6]), 64'h1);
        chk("indep_ch2", 64'(ov[0][2]), 64'h1);
        chk("indep_ch2_data", 64'(od[0][23:16]), 64'h77);

        // 300 words to sel=7: dropped on the N=6 router, delivered on the N=8 router
        tr = 8'hFF; ts = 3'd7;
        for (int i = 0; i < 300; i++) begin
            td = 8'($urandom);
            cycle();
        end
        chk("ill_drop_sat", 64'(dc[1]), 64'hFF);
        chk("ill_err", 64'(se[1]), 64'h1);
        chk("ill_no_valid", 64'(ov[1]), 64'h00);
        chk("legal_no_drop", 64'(dc[0]), 64'h00);
        chk("legal_no_err", 64'(se[0]), 64'h0);

`ifdef DEMUX_ROUTER_BCAST_EN
        // Broadcast blocked by stalled channel 1, then delivered to all
        tr = 8'hFD; ts = 3'd1; td = 8'h99;
        cycle();
        tbc = 1'b1; td = 8'h3C; ts = 3'd7;
        #1 chk("bc_blocked", 64'(ir[0]), 64'h0);
        cycle();
        tr = 8'hFF;
        #1 chk("bc_ready", 64'(ir[0]), 64'h1);
        cycle();
        chk("bc_valid8", 64'(ov[0]), 64'hFF);
        chk("bc_data8", od[0], {8{8'h3C}});
        chk("bc_valid6", 64'(ov[1]), 64'h3F);
        tbc = 1'b0;
`endif

        // Randomized traffic with occasional reset; producer holds while stalled
        for (int i = 0; i < 400; i++) begin
            resetn = ($urandom_range(0, 99) != 0);
            if (!last_stall) begin
                tv = 1'($urandom);
                td = 8'($urandom);
                ts = 3'($urandom);
`ifdef DEMUX_ROUTER_BCAST_EN
                tbc = tv && ($urandom_range(0, 7) == 0);
`endif
            end
            tr = 8'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
